// File: rtl/imem_loader_pkg.sv
// Shared constants for the serial instruction-memory boot loader.
package imem_loader_pkg;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  // Loader FSM encoding
  localparam logic [2:0] WAIT_SYNC = 3'd0;
  localparam logic [2:0] HDR_LO    = 3'd1;
  localparam logic [2:0] HDR_HI    = 3'd2;
  localparam logic [2:0] LOAD      = 3'd3;
  localparam logic [2:0] WRITE     = 3'd4;
  localparam logic [2:0] CHECK     = 3'd5;
  localparam logic [2:0] DONE      = 3'd6;
  localparam logic [2:0] ERROR     = 3'd7;

  // UART receiver encoding
  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: input synchronizer, mid-bit sampling, one-cycle byte strobe.
module uart_rx_byte
  import imem_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Rx,
  output logic       o_Valid,
  output logic [7:0] o_Byte,
  output logic       o_Frame_err
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntFull = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(CLKS_PER_BIT / 2 - 1);

  logic [1:0]      sync_q;
  logic            rx_prev_q;
  logic            rx_s;
  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;

  assign rx_s = sync_q[1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_s) begin
          state_d = RX_START;
          cnt_d   = '0;
        end
      end
      RX_START: begin
        // Re-check the start bit at mid-bit; a high line was a glitch.
        if (cnt_q == CntHalf) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == CntFull) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      RX_STOP: begin
        if (cnt_q == CntFull) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          valid_d = rx_s;
          ferr_d  = !rx_s;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      sync_q    <= 2'b11;
      rx_prev_q <= 1'b1;
      state_q   <= RX_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], i_Rx};
      rx_prev_q <= rx_s;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  assign o_Valid     = valid_q;
  assign o_Byte      = shift_q;
  assign o_Frame_err = ferr_q;

endmodule

// File: rtl/imem_loader.sv
// Serial boot loader: UART frame -> instruction-memory writes, holding the CPU until loaded.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte per frame.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst,
  input  logic                  i_Rx,
  output logic                  o_Wr_en,
  output logic [ADDR_WIDTH-1:0] o_Wr_addr,
  output logic [31:0]           o_Wr_data,
  output logic                  o_Cpu_hold,
  output logic                  o_Done,
  output logic                  o_Err
);

  localparam int unsigned IdxW  = ADDR_WIDTH + 1;
  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  logic            rx_valid;
  logic [7:0]      rx_byte;
  logic            rx_ferr;

  logic [2:0]      state_q, state_d;
  logic [15:0]     count_q, count_d;
  logic [IdxW-1:0] index_q, index_d;
  logic [31:0]     word_q, word_d;
  logic [1:0]      lane_q, lane_d;
  logic            err_q, err_d;
  logic [15:0]     hdr_count;
  logic [31:0]     next_index;
  logic [2:0]      st_after_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]      csum_q, csum_d;
`endif

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .i_Clk      (i_Clk),
    .i_Rst      (i_Rst),
    .i_Rx       (i_Rx),
    .o_Valid    (rx_valid),
    .o_Byte     (rx_byte),
    .o_Frame_err(rx_ferr)
  );

  assign hdr_count  = {rx_byte, count_q[7:0]};
  assign next_index = 32'(index_q) + 32'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign st_after_data = CHECK;
`else
  assign st_after_data = DONE;
`endif

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    index_d = index_q;
    word_d  = word_q;
    lane_d  = lane_q;
    err_d   = err_q | rx_ferr;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      WAIT_SYNC, DONE, ERROR: begin
        if (rx_valid && rx_byte == SYNC_BYTE) begin
          state_d = HDR_LO;
          index_d = '0;
        end
      end
      HDR_LO: begin
        if (rx_valid) begin
          count_d = {8'h00, rx_byte};
          state_d = HDR_HI;
        end
      end
      HDR_HI: begin
        if (rx_valid) begin
          count_d = hdr_count;
          index_d = '0;
          lane_d  = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d  = '0;
`endif
          if (hdr_count == 16'd0) begin
            state_d = st_after_data;
          end else if (32'(hdr_count) > Depth) begin
            state_d = ERROR;
            err_d   = 1'b1;
          end else begin
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        // Little-endian: each new byte enters at the top and shifts older bytes down.
        if (rx_valid) begin
          word_d = {rx_byte, word_q[31:8]};
          lane_d = lane_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d = csum_q ^ rx_byte;
`endif
          if (lane_q == 2'd3) state_d = WRITE;
        end
      end
      WRITE: begin
        index_d = index_q + IdxW'(1);
        state_d = (next_index < 32'(count_q)) ? LOAD : st_after_data;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHECK: begin
        if (rx_valid) begin
          if (rx_byte == csum_q) begin
            state_d = DONE;
          end else begin
            state_d = ERROR;
            err_d   = 1'b1;
          end
        end
      end
`endif
      default: state_d = WAIT_SYNC;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      state_q <= WAIT_SYNC;
      count_q <= '0;
      index_q <= '0;
      word_q  <= '0;
      lane_q  <= '0;
      err_q   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      index_q <= index_d;
      word_q  <= word_d;
      lane_q  <= lane_d;
      err_q   <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign o_Wr_en    = (state_q == WRITE);
  assign o_Wr_addr  = index_q[ADDR_WIDTH-1:0];
  assign o_Wr_data  = word_q;
  assign o_Cpu_hold = (state_q != DONE);
  assign o_Done     = (state_q == DONE);
  assign o_Err      = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized frame-level bench for imem_loader with an expected-write scoreboard.
module tb_imem_loader;

  localparam int CLKS  = 4;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          i_Clk = 1'b0;
  logic          i_Rst;
  logic          i_Rx;
  logic          o_Wr_en;
  logic [AW-1:0] o_Wr_addr;
  logic [31:0]   o_Wr_data;
  logic          o_Cpu_hold;
  logic          o_Done;
  logic          o_Err;

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] exp_addr_q[$];
  logic [31:0]   exp_data_q[$];
  logic [31:0]   wr_log[$];
  int            wr_count = 0;
  bit            m_done;
  bit            m_err;
  logic [31:0]   tx_words[0:DEPTH];

  imem_loader #(
    .CLKS_PER_BIT(CLKS),
    .ADDR_WIDTH  (AW),
    .SYNC_BYTE   (8'hA5)
  ) dut (
    .i_Clk     (i_Clk),
    .i_Rst     (i_Rst),
    .i_Rx      (i_Rx),
    .o_Wr_en   (o_Wr_en),
    .o_Wr_addr (o_Wr_addr),
    .o_Wr_data (o_Wr_data),
    .o_Cpu_hold(o_Cpu_hold),
    .o_Done    (o_Done),
    .o_Err     (o_Err)
  );

  always #5 i_Clk = ~i_Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Every write must match the head of the expected-write queue.
  always @(negedge i_Clk) begin
    if (i_Rst === 1'b1) begin
      check("hold_is_not_done", {31'b0, o_Cpu_hold}, {31'b0, !o_Done});
      if (o_Wr_en) begin
        wr_count++;
        wr_log.push_back(o_Wr_data);
        if (exp_data_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr %0h data %0h, expected no write",
                   o_Wr_addr, o_Wr_data);
        end else begin
          check("wr_addr", {28'b0, o_Wr_addr}, {28'b0, exp_addr_q.pop_front()});
          check("wr_data", o_Wr_data, exp_data_q.pop_front());
        end
      end
    end
  end

  task automatic send_bit(input logic b);
    i_Rx = b;
    repeat (CLKS) @(negedge i_Clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
    send_bit(1'b1);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_wr_en"}, {31'b0, o_Wr_en}, 32'd0);
    check({name, "_wr_addr"}, {28'b0, o_Wr_addr}, 32'd0);
    check({name, "_wr_data"}, o_Wr_data, 32'd0);
    check({name, "_hold"}, {31'b0, o_Cpu_hold}, 32'd1);
    check({name, "_done"}, {31'b0, o_Done}, 32'd0);
    check({name, "_err"}, {31'b0, o_Err}, 32'd0);
  endtask

  task automatic do_reset(input string name);
    @(negedge i_Clk);
    i_Rst = 1'b0;
    #1;
    check_reset_outputs(name);
    exp_addr_q.delete();
    exp_data_q.delete();
    m_done = 1'b0;
    m_err  = 1'b0;
    i_Rx   = 1'b1;
    repeat (3) @(negedge i_Clk);
    i_Rst = 1'b1;
    repeat (4) @(negedge i_Clk);
  endtask

  task automatic settle_and_check(input string name);
    repeat (3 * CLKS + 10) @(negedge i_Clk);
    check({name, "_pending_writes"}, exp_data_q.size(), 32'd0);
    check({name, "_done"}, {31'b0, o_Done}, {31'b0, m_done});
    check({name, "_hold"}, {31'b0, o_Cpu_hold}, {31'b0, !m_done});
    check({name, "_err"}, {31'b0, o_Err}, {31'b0, m_err});
  endtask

  // Frame-level model: N words from tx_words land at addresses 0..N-1 unless N is too large.
  task automatic send_frame(input int n, input bit bad_csum, input int drop_idx);
    logic [15:0] nn;
    logic [7:0]  cs;
    logic [7:0]  b;
    nn = 16'(n);
    cs = 8'h00;
    if (n > DEPTH) begin
      m_done = 1'b0;
      m_err  = 1'b1;
      send_byte(8'hA5, 1'b1);
      send_byte(nn[7:0], 1'b1);
      send_byte(nn[15:8], 1'b1);
      return;
    end
    for (int i = 0; i < n; i++) begin
      exp_addr_q.push_back(AW'(i));
      exp_data_q.push_back(tx_words[i]);
    end
    send_byte(8'hA5, 1'b1);
    send_byte(nn[7:0], 1'b1);
    send_byte(nn[15:8], 1'b1);
    for (int i = 0; i < 4 * n; i++) begin
      b = tx_words[i / 4][8 * (i % 4) +: 8];
      if (i == drop_idx) begin
        send_byte(b, 1'b0);
        m_err = 1'b1;
      end
      send_byte(b, 1'b1);
      cs = cs ^ b;
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(bad_csum ? (cs ^ 8'h01) : cs, 1'b1);
    m_done = !bad_csum;
    if (bad_csum) m_err = 1'b1;
`else
    m_done = 1'b1;
`endif
  endtask

  initial begin
    int base;
    i_Rx  = 1'b1;
    i_Rst = 1'b1;
    m_done = 1'b0;
    m_err  = 1'b0;
    #2 i_Rst = 1'b0;
    #1 check_reset_outputs("por");
    repeat (3) @(negedge i_Clk);
    i_Rst = 1'b1;

    // Idle line: no writes, CPU held.
    repeat (60) @(negedge i_Clk);
    settle_and_check("idle");

    // Two-word program.
    tx_words[0] = 32'h20000013;
    tx_words[1] = 32'h00000008;
    base = wr_log.size();
    send_frame(2, 1'b0, -1);
    settle_and_check("two_words");
    check("two_words_count", wr_log.size() - base, 32'd2);
    check("two_words_w0", wr_log[base], 32'h20000013);
    check("two_words_w1", wr_log[base + 1], 32'h00000008);
    check("two_words_done_lit", {31'b0, o_Done}, 32'd1);
    check("two_words_hold_lit", {31'b0, o_Cpu_hold}, 32'd0);

    // Leading noise ignored, empty program.
    base = wr_log.size();
    send_byte(8'h00, 1'b1);
    send_frame(0, 1'b0, -1);
    settle_and_check("empty");
    check("empty_count", wr_log.size() - base, 32'd0);
    check("empty_done_lit", {31'b0, o_Done}, 32'd1);

    // Oversize then recovery.
    base = wr_log.size();
    send_frame(17, 1'b0, -1);
    settle_and_check("oversize");
    check("oversize_err_lit", {31'b0, o_Err}, 32'd1);
    check("oversize_hold_lit", {31'b0, o_Cpu_hold}, 32'd1);
    check("oversize_count", wr_log.size() - base, 32'd0);
    tx_words[0] = 32'hCAFEF00D;
    send_frame(1, 1'b0, -1);
    settle_and_check("recover");
    check("recover_count", wr_log.size() - base, 32'd1);
    check("recover_done_lit", {31'b0, o_Done}, 32'd1);
    check("recover_err_lit", {31'b0, o_Err}, 32'd1);

    // Framing error on one data byte.
    do_reset("rst1");
    tx_words[0] = 32'h11223344;
    tx_words[1] = 32'h55667788;
    base = wr_log.size();
    send_frame(2, 1'b0, 3);
    settle_and_check("frame_err");
    check("frame_err_err_lit", {31'b0, o_Err}, 32'd1);
    check("frame_err_count", wr_log.size() - base, 32'd2);

    // Reset in the middle of a word aborts the load.
    base = wr_log.size();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h13, 1'b1);
    send_byte(8'h00, 1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    do_reset("mid_word");
    repeat (200) @(negedge i_Clk);
    settle_and_check("after_abort");
    check("after_abort_count", wr_log.size() - base, 32'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    tx_words[0] = 32'h04030201;
    base = wr_log.size();
    send_frame(1, 1'b0, -1);
    settle_and_check("csum_ok");
    check("csum_ok_done_lit", {31'b0, o_Done}, 32'd1);
    check("csum_ok_w0", wr_log[base], 32'h04030201);
    send_frame(1, 1'b1, -1);
    settle_and_check("csum_bad");
    check("csum_bad_hold_lit", {31'b0, o_Cpu_hold}, 32'd1);
    check("csum_bad_err_lit", {31'b0, o_Err}, 32'd1);
`endif

    // Randomized frames with noise and occasional faults.
    for (int f = 0; f < 10; f++) begin
      int n;
      int drop;
      bit bad;
      logic [7:0] noise;
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
        noise = 8'($urandom);
        if (noise == 8'hA5) noise = 8'h5A;
        send_byte(noise, 1'b1);
      end
      n = (f == 3) ? DEPTH : int'($urandom_range(0, DEPTH + 1));
      for (int i = 0; i < DEPTH; i++) tx_words[i] = $urandom;
      drop = ($urandom_range(0, 4) == 0 && n > 0 && n <= DEPTH) ?
             int'($urandom_range(0, 4 * n - 1)) : -1;
      bad  = ($urandom_range(0, 3) == 0);
      send_frame(n, bad, drop);
      settle_and_check("rand_frame");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Serial boot loader: the writer side of the instruction memory the CPU core only ever reads.
- Receives a program over an 8N1 UART line, assembles little-endian 32-bit words and drives a synchronous write port into instruction memory.
- Holds the CPU in reset until the load completes.
- Sits beside the core top; its hold output gates the core's reset and PC.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); minimum 4.
- ADDR_WIDTH, 8, word-address width of instruction memory; depth = 2**ADDR_WIDTH words.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- i_Clk  input  1  system clock
- i_Rst  input  1  asynchronous, active-low reset
- i_Rx  input  1  UART receive line, idle high, asynchronous to i_Clk
- o_Wr_en  output  1  one-cycle instruction-memory write strobe
- o_Wr_addr  output  ADDR_WIDTH  word address of write
- o_Wr_data  output  32  instruction word
- o_Cpu_hold  output  1  high = CPU held in reset
- o_Done  output  1  load completed successfully (level)
- o_Err  output  1  sticky error: framing, oversize or checksum

Behaviour:
- Reset (i_Rst low, asynchronous) values: o_Wr_en=0, o_Wr_addr=0, o_Wr_data=0, o_Cpu_hold=1, o_Done=0, o_Err=0; FSM=WAIT_SYNC; byte lane and word counters cleared. Reset mid-load aborts the load with no further writes.
- UART RX path:
  - i_Rx passes through a 2-flop synchronizer.
  - A falling edge starts a frame; start bit is re-checked at CLKS_PER_BIT/2 (high = glitch, return to idle).
  - 8 data bits sampled LSB first at full-bit intervals, then the stop bit.
  - Produces a one-cycle byte_valid pulse with the byte.
  - Stop bit 0: byte dropped, o_Err set.
- Frame format: SYNC_BYTE, count_lo, count_hi (16-bit word count N), then 4*N bytes, each word little-endian.
- FSM:
  - WAIT_SYNC: any byte other than SYNC_BYTE is ignored.
  - SYNC_BYTE -> HDR_LO -> HDR_HI. After HDR_HI:
    - N=0: go to DONE.
    - N > 2**ADDR_WIDTH: go to ERROR.
    - Otherwise: go to LOAD.
  - LOAD: shift bytes into lanes 0..3. On the 4th byte go to WRITE.
  - WRITE: lasts exactly one cycle. o_Wr_en=1, o_Wr_data=assembled word, o_Wr_addr=word index (starting at 0). Then index increments.
    - Returns to LOAD while index < N; else goes to DONE.
  - Write latency: o_Wr_en asserts on the cycle after the 4th byte_valid.
  - DONE: o_Cpu_hold=0, o_Done=1. Reception of SYNC_BYTE starts a reload: o_Done=0, o_Cpu_hold=1 the next cycle, index=0, go to HDR_LO.
  - ERROR: o_Cpu_hold=1, o_Done=0, no writes. Only SYNC_BYTE leaves it (-> HDR_LO). o_Err stays set until reset.
- Word-index counter is ADDR_WIDTH+1 bits so N = 2**ADDR_WIDTH is representable. The address never wraps.
- A byte arriving during WRITE cannot be lost: the minimum byte period (10*CLKS_PER_BIT) far exceeds one cycle.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - After the last data byte, one extra byte is expected: the XOR of all 4*N data bytes.
  - State CHECK compares it. Match -> DONE. Mismatch -> ERROR with o_Err=1; data already written stays, but the CPU stays held.
  - N=0 still expects a checksum byte of 8'h00.
- Not defined: no checksum byte; last WRITE goes straight to DONE.

Decomposition:
- Package imem_loader_pkg holds:
  - the FSM state enum (WAIT_SYNC, HDR_LO, HDR_HI, LOAD, WRITE, CHECK, DONE, ERROR)
  - SYNC_BYTE default
  - the UART sub-state enum (IDLE, START, DATA, STOP)
- One sub-module: uart_rx_byte. Ports: i_Clk, i_Rst, i_Rx, o_Valid, o_Byte, o_Frame_err; parameter CLKS_PER_BIT. It owns the synchronizer and bit timing.

Test Plan (CLKS_PER_BIT=4, ADDR_WIDTH=4):
- Reset then idle line -> o_Cpu_hold=1, o_Done=0, o_Wr_en never high.
- Send A5 02 00 13 00 00 20 08 00 00 00 -> writes addr0=32'h20000013, addr1=32'h00000008; o_Wr_en high exactly 2 cycles; then o_Done=1, o_Cpu_hold=0.
- Send 00 A5 00 00 -> leading 00 ignored; o_Done=1 with zero writes.
- Send A5 11 00 (N=17 > 16) -> ERROR; o_Err=1, o_Cpu_hold=1, no writes. A following valid A5 01 00 + 4 bytes -> one write, o_Done=1, o_Err still 1.
- Stop bit forced 0 on one data byte -> o_Err=1 and byte dropped, so the write fires one byte later; also assert i_Rst mid-word -> all outputs return to reset values immediately.
- With IMEM_LOADER_CHECKSUM_EN: A5 01 00 01 02 03 04 04 -> write then DONE; same frame with checksum 05 -> ERROR, o_Cpu_hold=1.
